// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit-side packet sequencer.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_PID    = 3'd2,
    ST_DATA   = 3'd3,
    ST_CRC_LO = 3'd4,
    ST_CRC_HI = 3'd5,
    ST_EOP    = 3'd6,
    ST_ERROR  = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    FT_SYNC   = 3'd0,
    FT_PID    = 3'd1,
    FT_DATA   = 3'd2,
    FT_CRC_LO = 3'd3,
    FT_CRC_HI = 3'd4,
    FT_EOP    = 3'd5
  } field_t;

  localparam logic [3:0] PID_NONE  = 4'b0000;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_PID     = 2'b01;
  localparam logic [1:0] ERR_LEN     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  function automatic logic is_data_pid(input logic [3:0] p);
    return (p == PID_DATA0) || (p == PID_DATA1);
  endfunction

  function automatic logic is_hs_pid(input logic [3:0] p);
    return (p == PID_ACK) || (p == PID_NAK) || (p == PID_STALL);
  endfunction

endpackage

// File: rtl/usb_tx_sequencer_if.sv
// Request, buffer and encoder handshake bundle of the TX sequencer.
// slave = sequencer side, master = protocol layer / buffer / encoder side.
interface usb_tx_sequencer_if #(
  parameter int LEN_W = 7
) ();
  logic [3:0]       tx_packet;
  logic [LEN_W-1:0] payload_len;
  logic             buf_empty;
  logic             field_ready;
  logic             eop_done;
  logic             field_valid;
  logic [2:0]       field_type;
  logic [3:0]       pid;
  logic             buf_pop;
  logic [LEN_W-1:0] byte_cnt;
  logic             tx_transfer_active;
  logic             tx_done;
  logic             tx_error;
  logic [1:0]       err_code;
  logic [2:0]       out_state;

  modport slave (
    input  tx_packet, payload_len, buf_empty, field_ready, eop_done,
    output field_valid, field_type, pid, buf_pop, byte_cnt,
           tx_transfer_active, tx_done, tx_error, err_code, out_state
  );

  modport master (
    output tx_packet, payload_len, buf_empty, field_ready, eop_done,
    input  field_valid, field_type, pid, buf_pop, byte_cnt,
           tx_transfer_active, tx_done, tx_error, err_code, out_state
  );
endinterface

// File: rtl/usb_tx_timeout_cnt.sv
// Saturating cycle counter; expired_o flags the enabled cycle that makes the
// count reach LIMIT, so the owner can leave on that same edge.
module usb_tx_timeout_cnt #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count enabled cycles and hold at LIMIT.
  always_comb begin
    // NOTE: default assigned first so every path drives cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != W'(LIMIT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every flop samples pre-edge values whatever the block order.
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && !clr_i && (cnt_q >= W'(LIMIT - 1));
endmodule

// File: rtl/usb_tx_sequencer.sv
// USB TX packet sequencer: walks the encoder through SYNC, PID, payload,
// CRC16 and EOP one field per handshake, with underflow and EOP timeouts.
module usb_tx_sequencer
  import usb_tx_pkg::*;
#(
  parameter int MAX_PAYLOAD     = 64,
  parameter int LEN_W           = $clog2(MAX_PAYLOAD + 1),
  parameter int UNDERFLOW_LIMIT = 16,
  parameter int EOP_TIMEOUT     = 32
) (
  input logic               clk,
  input logic               n_rst,
  usb_tx_sequencer_if.slave bus
);
  state_t           state_q, state_d;
  logic [3:0]       pid_q, pid_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
  logic             eop_sent_q, eop_sent_d;
  logic             tx_done_q, tx_done_d;
  logic             tx_error_q, tx_error_d;
  logic [1:0]       err_code_q, err_code_d;

  logic   field_valid, buf_pop;
  field_t field_type;
  logic   uf_clr, uf_en, uf_expired;
  logic   eop_clr, eop_en, eop_expired;

  usb_tx_timeout_cnt #(.LIMIT(UNDERFLOW_LIMIT)) u_underflow_cnt (
    .clk(clk), .n_rst(n_rst), .clr_i(uf_clr), .en_i(uf_en), .expired_o(uf_expired)
  );

  usb_tx_timeout_cnt #(.LIMIT(EOP_TIMEOUT)) u_eop_cnt (
    .clk(clk), .n_rst(n_rst), .clr_i(eop_clr), .en_i(eop_en), .expired_o(eop_expired)
  );

  // Next-state, field handshake and error decode.
  always_comb begin
    state_d     = state_q;
    pid_d       = pid_q;
    len_d       = len_q;
    byte_cnt_d  = byte_cnt_q;
    eop_sent_d  = eop_sent_q;
    tx_done_d   = 1'b0;
    tx_error_d  = tx_error_q;
    err_code_d  = err_code_q;
    field_valid = 1'b0;
    field_type  = FT_SYNC;
    buf_pop     = 1'b0;
    uf_clr      = 1'b1;
    uf_en       = 1'b0;
    eop_clr     = 1'b1;
    eop_en      = 1'b0;

    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (bus.tx_packet != PID_NONE) begin
          if (is_data_pid(bus.tx_packet) && (bus.payload_len > LEN_W'(MAX_PAYLOAD))) begin
            state_d    = ST_ERROR;
            tx_error_d = 1'b1;
            err_code_d = ERR_LEN;
          end else if (is_data_pid(bus.tx_packet) || is_hs_pid(bus.tx_packet)) begin
            state_d    = ST_SYNC;
            pid_d      = bus.tx_packet;
            len_d      = bus.payload_len;
            byte_cnt_d = '0;
            tx_error_d = 1'b0;
            err_code_d = ERR_NONE;
          end else begin
            state_d    = ST_ERROR;
            tx_error_d = 1'b1;
            err_code_d = ERR_PID;
          end
        end else if (state_q == ST_ERROR) begin
          state_d = ST_IDLE;
        end
      end
      ST_SYNC: begin
        field_valid = 1'b1;
        field_type  = FT_SYNC;
        if (bus.field_ready) state_d = ST_PID;
      end
      ST_PID: begin
        field_valid = 1'b1;
        field_type  = FT_PID;
        if (bus.field_ready) begin
          if (!is_data_pid(pid_q))  state_d = ST_EOP;
          else if (len_q == '0)     state_d = ST_CRC_LO;
          else                      state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        field_type = FT_DATA;
        uf_clr     = 1'b0;
        uf_en      = bus.buf_empty;
        if (uf_expired) begin
          state_d    = ST_ERROR;
          tx_error_d = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end else begin
          field_valid = !bus.buf_empty;
          buf_pop     = field_valid && bus.field_ready;
          if (buf_pop) begin
            uf_clr     = 1'b1;
            byte_cnt_d = byte_cnt_q + LEN_W'(1);
            if (byte_cnt_d == len_q) state_d = ST_CRC_LO;
          end
        end
      end
      ST_CRC_LO: begin
        field_valid = 1'b1;
        field_type  = FT_CRC_LO;
        if (bus.field_ready) state_d = ST_CRC_HI;
      end
      ST_CRC_HI: begin
        field_valid = 1'b1;
        field_type  = FT_CRC_HI;
        if (bus.field_ready) state_d = ST_EOP;
      end
      ST_EOP: begin
        field_type = FT_EOP;
        if (!eop_sent_q) begin
          // eop_done before the EOP field is accepted is deliberately ignored.
          field_valid = 1'b1;
          if (bus.field_ready) eop_sent_d = 1'b1;
        end else if (bus.eop_done) begin
          state_d    = ST_IDLE;
          tx_done_d  = 1'b1;
          eop_sent_d = 1'b0;
        end else begin
          eop_clr = 1'b0;
          eop_en  = 1'b1;
          if (eop_expired) begin
            state_d    = ST_ERROR;
            tx_error_d = 1'b1;
            err_code_d = ERR_TIMEOUT;
            eop_sent_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and status registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      pid_q      <= '0;
      len_q      <= '0;
      byte_cnt_q <= '0;
      eop_sent_q <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_error_q <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      pid_q      <= pid_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      eop_sent_q <= eop_sent_d;
      tx_done_q  <= tx_done_d;
      tx_error_q <= tx_error_d;
      err_code_q <= err_code_d;
    end
  end

  assign bus.field_valid        = field_valid;
  assign bus.field_type         = field_type;
  assign bus.buf_pop            = buf_pop;
  assign bus.pid                = pid_q;
  assign bus.byte_cnt           = byte_cnt_q;
  assign bus.tx_transfer_active = (state_q != ST_IDLE) && (state_q != ST_ERROR);
  assign bus.tx_done            = tx_done_q;
  assign bus.tx_error           = tx_error_q;
  assign bus.err_code           = err_code_q;
  assign bus.out_state          = state_q;
endmodule
